// File: rtl/frame_update_scheduler.sv
// Collects rover location/move/orientation updates and commits them to the display
// registers only on a vsync falling edge, so the rendered frame never tears.
module frame_update_scheduler #(
   parameter int TIMEOUT_FRAMES = 60
) (
   input  logic        vclock,
   input  logic        reset,
   input  logic        vsync,
   input  logic        new_data,
   input  logic [11:0] location,
   input  logic [11:0] move_command,
   input  logic        orientation_ready,
   input  logic [5:0]  orientation,
   input  logic [3:0]  target_location,
   output logic [11:0] disp_location,
   output logic [11:0] disp_move_command,
   output logic [5:0]  disp_orientation,
   output logic [3:0]  disp_target,
   output logic        disp_valid,
   output logic        frame_update,
   output logic        orient_stale,
   output logic        busy,
   output logic [7:0]  drop_count
);

   localparam int CNT_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, WAIT_ORIENT, WAIT_FRAME} state_t;

   state_t           state_q, state_d;
   logic             vsync_prev_q;
   logic             fb;
   logic [11:0]      pend_loc_q, pend_loc_d;
   logic [11:0]      pend_move_q, pend_move_d;
   logic [5:0]       pend_orient_q, pend_orient_d;
   logic             stale_q, stale_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]       drop_q, drop_d;
   logic             drop_inc, commit;
   logic [11:0]      disp_loc_q, disp_loc_d;
   logic [11:0]      disp_move_q, disp_move_d;
   logic [5:0]       disp_orient_q, disp_orient_d;
   logic [3:0]       disp_target_q, disp_target_d;
   logic             disp_valid_q, disp_valid_d;
   logic             frame_update_q, frame_update_d;
   logic             orient_stale_q, orient_stale_d;

   assign fb = vsync_prev_q & ~vsync;

   always_comb begin
      state_d       = state_q;
      pend_loc_d    = pend_loc_q;
      pend_move_d   = pend_move_q;
      // Orientation is always captured; only WAIT_ORIENT treats it as a state event.
      pend_orient_d = orientation_ready ? orientation : pend_orient_q;
      stale_d       = stale_q;
      frame_cnt_d   = frame_cnt_q;
      drop_inc      = 1'b0;
      commit        = 1'b0;
      case (state_q)
         IDLE: begin
            if (new_data) begin
               pend_loc_d  = location;
               pend_move_d = move_command;
               frame_cnt_d = '0;
               state_d     = WAIT_ORIENT;
            end
         end
         WAIT_ORIENT: begin
            if (orientation_ready) begin
               stale_d = 1'b0;
               state_d = WAIT_FRAME;
            end else if (fb) begin
               if (frame_cnt_q == CNT_LAST) begin
                  stale_d = 1'b1;
                  state_d = WAIT_FRAME;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
            if (new_data) begin
               pend_loc_d  = location;
               pend_move_d = move_command;
               frame_cnt_d = '0;
               drop_inc    = 1'b1;
            end
         end
         WAIT_FRAME: begin
            if (fb) begin
               commit = 1'b1;
               if (new_data) begin
                  pend_loc_d  = location;
                  pend_move_d = move_command;
                  frame_cnt_d = '0;
                  state_d     = WAIT_ORIENT;
               end else begin
                  state_d = IDLE;
               end
            end else if (new_data) begin
               pend_loc_d  = location;
               pend_move_d = move_command;
               drop_inc    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

      // Commit uses the pending values as they stood before this cycle's updates.
      disp_loc_d     = commit ? pend_loc_q    : disp_loc_q;
      disp_move_d    = commit ? pend_move_q   : disp_move_q;
      disp_orient_d  = commit ? pend_orient_q : disp_orient_q;
      orient_stale_d = commit ? stale_q       : orient_stale_q;
      disp_valid_d   = disp_valid_q | commit;
      frame_update_d = commit;
      disp_target_d  = fb ? target_location : disp_target_q;
   end

   always_ff @(posedge vclock) begin
      if (reset) begin
         state_q        <= IDLE;
         vsync_prev_q   <= 1'b1;
         pend_loc_q     <= '0;
         pend_move_q    <= '0;
         pend_orient_q  <= '0;
         stale_q        <= 1'b0;
         frame_cnt_q    <= '0;
         drop_q         <= '0;
         disp_loc_q     <= '0;
         disp_move_q    <= '0;
         disp_orient_q  <= '0;
         disp_target_q  <= '0;
         disp_valid_q   <= 1'b0;
         frame_update_q <= 1'b0;
         orient_stale_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         vsync_prev_q   <= vsync;
         pend_loc_q     <= pend_loc_d;
         pend_move_q    <= pend_move_d;
         pend_orient_q  <= pend_orient_d;
         stale_q        <= stale_d;
         frame_cnt_q    <= frame_cnt_d;
         drop_q         <= drop_d;
         disp_loc_q     <= disp_loc_d;
         disp_move_q    <= disp_move_d;
         disp_orient_q  <= disp_orient_d;
         disp_target_q  <= disp_target_d;
         disp_valid_q   <= disp_valid_d;
         frame_update_q <= frame_update_d;
         orient_stale_q <= orient_stale_d;
      end
   end

   assign disp_location     = disp_loc_q;
   assign disp_move_command = disp_move_q;
   assign disp_orientation  = disp_orient_q;
   assign disp_target       = disp_target_q;
   assign disp_valid        = disp_valid_q;
   assign frame_update      = frame_update_q;
   assign orient_stale      = orient_stale_q;
   assign busy              = (state_q != IDLE);
   assign drop_count        = drop_q;

endmodule
